// File: rtl/pattern_window_3x3.sv
// 3x3 sliding-window template matcher: builds a raster-order window from the
// current pixel and two line-delay taps, scores it by SAD and flags matches.
module pattern_window_3x3 #(
    parameter int WIDTH  = 1280,
    parameter int HEIGHT = 720
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  pix_in,
    input  logic [7:0]  tap1,
    input  logic [7:0]  tap2,
    input  logic        tmpl_we,
    input  logic [3:0]  tmpl_addr,
    input  logic [7:0]  tmpl_data,
    input  logic [11:0] threshold,
    output logic        out_valid,
    output logic [11:0] sad,
    output logic        match,
    output logic [10:0] out_col,
    output logic [9:0]  out_row,
    output logic        frame_done
);

    localparam logic [10:0] COL_LAST = 11'(WIDTH - 1);
    localparam logic [9:0]  ROW_LAST = 10'(HEIGHT - 1);

    function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        if (a >= b) begin
            r = a - b;
        end else begin
            r = b - a;
        end
        return r;
    endfunction

    logic [10:0] col_q, col_d;
    logic [9:0]  row_q, row_d;
    logic [7:0]  w_q    [9];
    logic [7:0]  w_d    [9];
    logic [7:0]  tmpl_q [9];
    logic [7:0]  tmpl_d [9];

    logic        v1_q, v1_d;
    logic [10:0] c1_q, c1_d;
    logic [9:0]  r1_q, r1_d;

    logic [7:0]  diff_q [9];
    logic [7:0]  diff_d [9];
    logic        v2_q, v2_d;
    logic [10:0] c2_q, c2_d;
    logic [9:0]  r2_q, r2_d;

    logic        out_valid_q, out_valid_d;
    logic [11:0] sad_q, sad_d;
    logic        match_q, match_d;
    logic [10:0] out_col_q, out_col_d;
    logic [9:0]  out_row_q, out_row_d;
    logic        frame_done_q, frame_done_d;
    logic [11:0] sum_s;

    // Raster counters and stage-1 tags; the pre-increment position decides window validity.
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        v1_d         = 1'b0;
        c1_d         = c1_q;
        r1_d         = r1_q;
        frame_done_d = 1'b0;
        if (in_valid) begin
            v1_d         = (col_q >= 11'd2) && (row_q >= 10'd2);
            c1_d         = col_q - 11'd1;
            r1_d         = row_q - 10'd1;
            frame_done_d = (col_q == COL_LAST) && (row_q == ROW_LAST);
            if (col_q == COL_LAST) begin
                col_d = 11'd0;
                if (row_q == ROW_LAST) begin
                    row_d = 10'd0;
                end else begin
                    row_d = row_q + 10'd1;
                end
            end else begin
                col_d = col_q + 11'd1;
                row_d = row_q;
            end
        end else begin
            v1_d         = 1'b0;
            frame_done_d = 1'b0;
        end
    end

    // Window shift: index r*3+c, column 2 is the newest, row 0 is the oldest line.
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            w_d[i] = w_q[i];
        end
        if (in_valid) begin
            for (int r = 0; r < 3; r++) begin
                w_d[r*3+0] = w_q[r*3+1];
                w_d[r*3+1] = w_q[r*3+2];
            end
            w_d[2] = tap2;
            w_d[5] = tap1;
            w_d[8] = pix_in;
        end else begin
            for (int i = 0; i < 9; i++) begin
                w_d[i] = w_q[i];
            end
        end
    end

    // Template write port; out-of-range addresses are dropped.
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            tmpl_d[i] = tmpl_q[i];
        end
        if (tmpl_we && (tmpl_addr <= 4'd8)) begin
            tmpl_d[tmpl_addr] = tmpl_data;
        end else begin
            for (int i = 0; i < 9; i++) begin
                tmpl_d[i] = tmpl_q[i];
            end
        end
    end

    // Stage 2 uses the template as it stood before this edge, so a
    // coincident write only affects the following window.
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            diff_d[i] = abs_diff(w_q[i], tmpl_q[i]);
        end
        v2_d = v1_q;
        c2_d = c1_q;
        r2_d = r1_q;
    end

    // Stage 3: sum fits in 12 bits (9 * 255 = 2295); outputs hold across bubbles.
    always_comb begin
        sum_s = 12'd0;
        for (int i = 0; i < 9; i++) begin
            sum_s = sum_s + {4'd0, diff_q[i]};
        end
        out_valid_d = v2_q;
        sad_d       = sad_q;
        match_d     = match_q;
        out_col_d   = out_col_q;
        out_row_d   = out_row_q;
        if (v2_q) begin
            sad_d     = sum_s;
            match_d   = (sum_s <= threshold);
            out_col_d = c2_q;
            out_row_d = r2_q;
        end else begin
            sad_d     = sad_q;
            match_d   = match_q;
        end
    end

    // All state, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q        <= 11'd0;
            row_q        <= 10'd0;
            v1_q         <= 1'b0;
            c1_q         <= 11'd0;
            r1_q         <= 10'd0;
            v2_q         <= 1'b0;
            c2_q         <= 11'd0;
            r2_q         <= 10'd0;
            out_valid_q  <= 1'b0;
            sad_q        <= 12'd0;
            match_q      <= 1'b0;
            out_col_q    <= 11'd0;
            out_row_q    <= 10'd0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                w_q[i]    <= 8'd0;
                tmpl_q[i] <= 8'd0;
                diff_q[i] <= 8'd0;
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            v1_q         <= v1_d;
            c1_q         <= c1_d;
            r1_q         <= r1_d;
            v2_q         <= v2_d;
            c2_q         <= c2_d;
            r2_q         <= r2_d;
            out_valid_q  <= out_valid_d;
            sad_q        <= sad_d;
            match_q      <= match_d;
            out_col_q    <= out_col_d;
            out_row_q    <= out_row_d;
            frame_done_q <= frame_done_d;
            for (int i = 0; i < 9; i++) begin
                w_q[i]    <= w_d[i];
                tmpl_q[i] <= tmpl_d[i];
                diff_q[i] <= diff_d[i];
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign sad        = sad_q;
    assign match      = match_q;
    assign out_col    = out_col_q;
    assign out_row    = out_row_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pattern_window_3x3.sv
// Scoreboard bench for pattern_window_3x3 on an 8x6 frame: the driver pushes
// expected results from an image/template model, a negedge monitor pops them.
module tb_pattern_window_3x3;

    localparam int W = 8;
    localparam int H = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  pix_in, tap1, tap2;
    logic        tmpl_we;
    logic [3:0]  tmpl_addr;
    logic [7:0]  tmpl_data;
    logic [11:0] threshold;
    logic        out_valid;
    logic [11:0] sad;
    logic        match;
    logic [10:0] out_col;
    logic [9:0]  out_row;
    logic        frame_done;

    pattern_window_3x3 #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .pix_in(pix_in),
        .tap1(tap1), .tap2(tap2), .tmpl_we(tmpl_we), .tmpl_addr(tmpl_addr),
        .tmpl_data(tmpl_data), .threshold(threshold), .out_valid(out_valid),
        .sad(sad), .match(match), .out_col(out_col), .out_row(out_row),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] sad;
        logic        match;
        logic [10:0] col;
        logic [9:0]  row;
        int          edge_n;
    } exp_t;

    exp_t        sb[$];
    int          chk_cnt = 0;
    int          pass_cnt = 0;
    int          edge_cnt = 0;
    int          fd_edge = -1;
    int          res_cnt = 0;
    int          fd_cnt = 0;
    int          mcol = 0;
    int          mrow = 0;
    logic [7:0]  tmpl_m [9];

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input longint act, input longint exp);
        chk_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    function automatic int pix_of(input int mode, input int c, input int r);
        case (mode)
            0: return 100;
            1: return 110;
            2: return 255;
            default: return (c * 37 + r * 59 + c * r * 11) & 255;
        endcase
    endfunction

    task automatic drive_pix(input int mode, input bit wr, input logic [3:0] waddr,
                             input logic [7:0] wdata);
        exp_t e;
        int   s;
        bit   win;
        in_valid  = 1'b1;
        pix_in    = 8'(pix_of(mode, mcol, mrow));
        tap1      = 8'(pix_of(mode, mcol, mrow - 1));
        tap2      = 8'(pix_of(mode, mcol, mrow - 2));
        tmpl_we   = wr;
        tmpl_addr = waddr;
        tmpl_data = wdata;
        if (wr && waddr <= 4'd8) tmpl_m[waddr] = wdata;
        win = (mcol >= 2) && (mrow >= 2);
        s = 0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                int p, t;
                p = pix_of(mode, mcol - 2 + c, mrow - 2 + r);
                t = int'(tmpl_m[r*3+c]);
                s += (p > t) ? (p - t) : (t - p);
            end
        end
        e.sad   = 12'(s);
        e.match = (s <= int'(threshold));
        e.col   = 11'(mcol - 1);
        e.row   = 10'(mrow - 1);
        @(posedge clk);
        #1;
        e.edge_n = edge_cnt;
        if (win) sb.push_back(e);
        if (mcol == W - 1 && mrow == H - 1) fd_edge = edge_cnt;
        if (mcol == W - 1) begin
            mcol = 0;
            mrow = (mrow == H - 1) ? 0 : mrow + 1;
        end else begin
            mcol++;
        end
        in_valid = 1'b0;
        tmpl_we  = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        tmpl_we  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_tmpl(input logic [3:0] addr, input logic [7:0] data);
        tmpl_we   = 1'b1;
        tmpl_addr = addr;
        tmpl_data = data;
        if (addr <= 4'd8) tmpl_m[addr] = data;
        @(posedge clk);
        #1;
        tmpl_we = 1'b0;
    endtask

    task automatic run_frame(input int mode, input bit bubbles, input int wc, input int wr_row,
                             input logic [3:0] waddr, input logic [7:0] wdata);
        res_cnt = 0;
        fd_cnt  = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (bubbles && $urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
                drive_pix(mode, (c == wc && r == wr_row), waddr, wdata);
            end
        end
        idle(5);
        check("result_count", longint'(res_cnt), longint'((W - 2) * (H - 2)));
        check("scoreboard_drained", longint'(sb.size()), 0);
        check("frame_done_count", longint'(fd_cnt), 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_out_valid"}, longint'(out_valid), 0);
        check({tag, "_sad"}, longint'(sad), 0);
        check({tag, "_match"}, longint'(match), 0);
        check({tag, "_out_col"}, longint'(out_col), 0);
        check({tag, "_out_row"}, longint'(out_row), 0);
        check({tag, "_frame_done"}, longint'(frame_done), 0);
    endtask

    // Monitor: compares every presented result against the scoreboard head.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result_sad_match_col_row", longint'({sad, match, out_col, out_row}),
                          longint'({e.sad, e.match, e.col, e.row}));
                    check("latency_edges", longint'(edge_cnt - e.edge_n), 2);
                end
                res_cnt++;
            end
            if (frame_done || edge_cnt == fd_edge) begin
                check("frame_done_timing", longint'(frame_done), longint'(edge_cnt == fd_edge));
                if (frame_done) fd_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; pix_in = 8'd0; tap1 = 8'd0; tap2 = 8'd0;
        tmpl_we = 1'b0; tmpl_addr = 4'd0; tmpl_data = 8'd0; threshold = 12'd0;
        for (int i = 0; i < 9; i++) tmpl_m[i] = 8'd0;
        #23;
        check_outputs_zero("reset_init");
        #4 reset = 1'b0;
        idle(2);

        // Uniform 100 vs template 100: perfect match at threshold 0.
        for (int i = 0; i < 9; i++) write_tmpl(4'(i), 8'd100);
        threshold = 12'd0;
        run_frame(0, 1'b0, -1, -1, 4'd0, 8'd0);

        // Uniform 110: sad 90, threshold boundary 89 / 90.
        threshold = 12'd89;
        run_frame(1, 1'b0, -1, -1, 4'd0, 8'd0);
        threshold = 12'd90;
        run_frame(1, 1'b0, -1, -1, 4'd0, 8'd0);

        // Maximum SAD; out-of-range writes must not disturb the template.
        for (int i = 0; i < 9; i++) write_tmpl(4'(i), 8'd0);
        for (int a = 9; a < 16; a++) write_tmpl(4'(a), 8'd77);
        threshold = 12'd4095;
        run_frame(2, 1'b0, -1, -1, 4'd0, 8'd0);

        // Gradient image, template change of centre tap at pixel (4,3).
        for (int i = 0; i < 9; i++) write_tmpl(4'(i), 8'(i * 25));
        threshold = 12'd600;
        run_frame(3, 1'b0, 4, 3, 4'd4, 8'd50);

        // Same image with random bubbles.
        run_frame(3, 1'b1, -1, -1, 4'd0, 8'd0);

        // Partial frame, then asynchronous reset mid-stream.
        res_cnt = 0;
        for (int k = 0; k < 27; k++) drive_pix(3, 1'b0, 4'd0, 8'd0);
        check("pre_reset_results_seen", longint'(res_cnt > 0), 1);
        #2 reset = 1'b1;
        #1;
        check_outputs_zero("reset_mid");
        sb.delete();
        mcol = 0; mrow = 0; fd_edge = -1;
        for (int i = 0; i < 9; i++) tmpl_m[i] = 8'd0;
        idle(2);
        reset = 1'b0;
        idle(1);
        for (int i = 0; i < 9; i++) write_tmpl(4'(i), 8'(200 - i * 15));
        threshold = 12'd700;
        run_frame(3, 1'b0, -1, -1, 4'd0, 8'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
